// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: N-phase intersection controller.
// Serves approaches in round-robin order and skips any phase without latched
// demand. Each green is bounded by min/max green with gap-out, then a fixed
// yellow and an all-red clearance. The light output is registered so it
// changes on the same edge as the state, and it feeds the lamp mux directly.

module traffic_phase_controller #(
  parameter int NUM_PHASES  = 4,
  parameter int PHASE_W     = 2,
  parameter int TIMER_W     = 16,
  parameter int MIN_GREEN   = 10,
  parameter int MAX_GREEN   = 50,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PHASES-1:0]   sensor,
  output logic [2*NUM_PHASES-1:0] light,
  output logic [PHASE_W-1:0]      active_phase,
  output logic                    phase_done
);

  localparam logic [1:0] ST_ALLRED = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;

  localparam logic [1:0] LAMP_RED    = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;
  localparam logic [1:0] LAMP_GREEN  = 2'b11;

  localparam logic [TIMER_W-1:0] T_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] T_MIN   = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_MAX   = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_YEL   = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] T_AR    = TIMER_W'(ALLRED_TIME - 1);
  localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(NUM_PHASES - 1);
  localparam longint T_LIMIT = 64'd1 << TIMER_W;

  // Reject parameter sets the counters and phase index cannot represent.
  if (NUM_PHASES < 2) begin : g_chk_phases
    $error("traffic_phase_controller: NUM_PHASES must be >= 2");
  end
  if (PHASE_W < $clog2(NUM_PHASES)) begin : g_chk_phase_w
    $error("traffic_phase_controller: PHASE_W too narrow for NUM_PHASES");
  end
  if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN) begin : g_chk_green
    $error("traffic_phase_controller: need 1 <= MIN_GREEN <= MAX_GREEN");
  end
  if (YELLOW_TIME < 1 || ALLRED_TIME < 1) begin : g_chk_clear
    $error("traffic_phase_controller: YELLOW_TIME and ALLRED_TIME must be >= 1");
  end
  if (longint'(MAX_GREEN) >= T_LIMIT || longint'(YELLOW_TIME) >= T_LIMIT ||
      longint'(ALLRED_TIME) >= T_LIMIT || longint'(MIN_GREEN) >= T_LIMIT) begin : g_chk_timer
    $error("traffic_phase_controller: interval does not fit in TIMER_W");
  end

  logic [1:0]              state, state_nx;
  logic [TIMER_W-1:0]      timer, timer_nx;
  logic [NUM_PHASES-1:0]   demand, demand_nx;
  logic [PHASE_W-1:0]      phase_nx;
  logic [2*NUM_PHASES-1:0] light_nx;
  logic                    other_demand, act_sensor;
  logic                    found_hi, found_lo, grant, terminate;
  logic [PHASE_W-1:0]      hi_idx, lo_idx;

  // Demand summary: the round-robin candidate is the lowest demanded index
  // above the active phase, otherwise the lowest demanded index at or below it.
  always_comb begin
    other_demand = 1'b0;
    act_sensor   = 1'b0;
    found_hi     = 1'b0;
    found_lo     = 1'b0;
    hi_idx       = '0;
    lo_idx       = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (PHASE_W'(i) == active_phase) begin
        act_sensor = sensor[i];
      end else if (demand[i]) begin
        other_demand = 1'b1;
      end
      if (demand[i]) begin
        if (PHASE_W'(i) > active_phase) begin
          found_hi = 1'b1;
          hi_idx   = PHASE_W'(i);
        end else begin
          found_lo = 1'b1;
          lo_idx   = PHASE_W'(i);
        end
      end
    end
  end

  // Next state, interval timer (down-count in ALLRED/YELLOW, green age in GREEN), demand and lamps.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    phase_nx  = active_phase;
    grant     = 1'b0;
    terminate = other_demand &&
                (((timer >= T_MIN) && !act_sensor) || (timer == T_MAX));
    case (state)
      ST_ALLRED: begin
        if (timer != '0) begin
          timer_nx = timer - T_ONE;
        end else if (found_hi || found_lo) begin
          state_nx = ST_GREEN;
          phase_nx = found_hi ? hi_idx : lo_idx;
          timer_nx = '0;
          grant    = 1'b1;
        end
      end
      ST_GREEN: begin
        if (terminate) begin
          state_nx = ST_YELLOW;
          timer_nx = T_YEL;
        end else if (timer != T_MAX) begin
          timer_nx = timer + T_ONE;
        end
      end
      ST_YELLOW: begin
        if (timer == '0) begin
          state_nx = ST_ALLRED;
          timer_nx = T_AR;
        end else begin
          timer_nx = timer - T_ONE;
        end
      end
      default: begin
        state_nx = ST_ALLRED;
        timer_nx = T_AR;
      end
    endcase

    demand_nx = demand;
    light_nx  = {NUM_PHASES{LAMP_RED}};
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (sensor[i] && !(state == ST_GREEN && PHASE_W'(i) == active_phase)) begin
        demand_nx[i] = 1'b1;
      end
      if (grant && PHASE_W'(i) == phase_nx) begin
        demand_nx[i] = 1'b0;
      end
      if (PHASE_W'(i) == phase_nx) begin
        if (state_nx == ST_GREEN) begin
          light_nx[2*i +: 2] = LAMP_GREEN;
        end else if (state_nx == ST_YELLOW) begin
          light_nx[2*i +: 2] = LAMP_YELLOW;
        end
      end
    end
  end

  // Register state, timer, demand latches, granted phase and lamp codes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_ALLRED;
      timer        <= T_AR;
      demand       <= '0;
      active_phase <= LAST_PH;
      light        <= {NUM_PHASES{LAMP_RED}};
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      demand       <= demand_nx;
      active_phase <= phase_nx;
      light        <= light_nx;
    end
  end

  assign phase_done = (state == ST_YELLOW) && (timer == '0);

endmodule
